data_fifo: RTL and testbench

- Synchronous single-clock circular-buffer FIFO for DATA_WIDTH-bit samples between a producer (valid-only push) and a consumer (request-driven pop).
- First-word-fall-through output: the head word is visible on out_data whenever the FIFO is non-empty.
- Exposes occupancy, read pointer and an overflow event, so control logic can monitor buffering of measurement samples.

---
 rtl/data_fifo.sv | 92 +++++++++
 tb/tb_data_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_fifo.sv
// Single-clock circular-buffer FIFO with first-word-fall-through output and overflow pulse.
// Define FIFO_UNDERFLOW_EN to add the event_underflow output.
module data_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_SIZE  = 1024,
    localparam int unsigned FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_data_vld,
    output logic                       out_data_rdy,
    input  logic                       out_data_vld,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [FIFO_SIZE_WIDTH-1:0] out_data_ptr,
    output logic [FIFO_SIZE_WIDTH-1:0] fifo_size,
    output logic                       event_overflow
`ifdef FIFO_UNDERFLOW_EN
    ,
    output logic                       event_underflow
`endif
);

    logic [DATA_WIDTH-1:0]      mem_q [FIFO_SIZE];
    logic [FIFO_SIZE_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_SIZE_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_SIZE_WIDTH-1:0] count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic                       empty, full, push, pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FIFO_SIZE_WIDTH'(FIFO_SIZE - 1));
        pop   = out_data_vld && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        push  = in_data_vld && (!full || pop);

        wr_ptr_d = push ? wr_ptr_q + FIFO_SIZE_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_SIZE_WIDTH'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + FIFO_SIZE_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - FIFO_SIZE_WIDTH'(1);
        end

        overflow_d = in_data_vld && !push;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef FIFO_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= out_data_vld && empty;
        end
    end

    assign event_underflow = underflow_q;
`endif

    assign out_data_rdy   = !empty;
    assign out_data       = empty ? '0 : mem_q[rd_ptr_q];
    assign out_data_ptr   = rd_ptr_q;
    assign fifo_size      = count_q;
    assign event_overflow = overflow_q;

endmodule

// File: tb/tb_data_fifo.sv
// Scoreboard bench for data_fifo: stimulus queues accepted words, a monitor checks each pop.
// Define FIFO_UNDERFLOW_EN to also exercise event_underflow.
module tb_data_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_data_vld;
    logic        out_data_rdy;
    logic        out_data_vld;
    logic [31:0] out_data;
    logic [9:0]  out_data_ptr;
    logic [9:0]  fifo_size;
    logic        event_overflow;
`ifdef FIFO_UNDERFLOW_EN
    logic        event_underflow;
`endif

    int unsigned n_vec;
    int unsigned n_fail;
    logic [31:0] exp_q[$];
    logic [9:0]  m_rd;

    data_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_data_vld    (in_data_vld),
        .out_data_rdy   (out_data_rdy),
        .out_data_vld   (out_data_vld),
        .out_data       (out_data),
        .out_data_ptr   (out_data_ptr),
        .fifo_size      (fifo_size),
        .event_overflow (event_overflow)
`ifdef FIFO_UNDERFLOW_EN
        ,
        .event_underflow(event_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the pop handshake completes at the next rising edge.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out_data_rdy && out_data_vld) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_model_empty", {63'd0, out_data_rdy}, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("pop_data", {32'd0, out_data}, {32'd0, exp});
                end
            end
        end
    end

    // One clock of stimulus; expected state is derived from the model queue depth.
    task automatic cycle(input bit push, input logic [31:0] d, input bit pop);
        int unsigned sz;
        bit pop_ok, acc, ovf, unf;
        sz     = exp_q.size();
        pop_ok = pop && (sz > 0);
        acc    = push && ((sz < 1023) || pop_ok);
        ovf    = push && !acc;
        unf    = pop && (sz == 0);
        in_data     = d;
        in_data_vld = push;
        out_data_vld = pop;
        @(posedge clk);
        if (acc) exp_q.push_back(d);
        if (pop_ok) m_rd = m_rd + 10'd1;
        #1;
        check("fifo_size", {54'd0, fifo_size}, 64'(exp_q.size()));
        check("out_data_rdy", {63'd0, out_data_rdy}, {63'd0, exp_q.size() != 0});
        check("out_data_ptr", {54'd0, out_data_ptr}, {54'd0, m_rd});
        check("event_overflow", {63'd0, event_overflow}, {63'd0, ovf});
        check("out_data_head", {32'd0, out_data},
              {32'd0, (exp_q.size() != 0) ? exp_q[0] : 32'd0});
`ifdef FIFO_UNDERFLOW_EN
        check("event_underflow", {63'd0, event_underflow}, {63'd0, unf});
`else
        unf = 1'b0;
`endif
        in_data_vld  = 1'b0;
        out_data_vld = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        m_rd = '0;
        rst = 1'b1;
        in_data = '0;
        in_data_vld = 1'b0;
        out_data_vld = 1'b0;
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_fifo_size", {54'd0, fifo_size}, 64'd0);
        check("reset_rdy", {63'd0, out_data_rdy}, 64'd0);
        check("reset_out_data", {32'd0, out_data}, 64'd0);
        check("reset_ptr", {54'd0, out_data_ptr}, 64'd0);
        check("reset_overflow", {63'd0, event_overflow}, 64'd0);

        cycle(1'b1, 32'h0000_0001, 1'b0);
        cycle(1'b1, 32'h0000_0002, 1'b0);
        check("two_push_size", {54'd0, fifo_size}, 64'd2);
        check("two_push_rdy", {63'd0, out_data_rdy}, 64'd1);
        check("two_push_head", {32'd0, out_data}, 64'h1);
        check("two_push_ptr", {54'd0, out_data_ptr}, 64'd0);

        cycle(1'b0, 32'd0, 1'b1);
        check("first_pop_head", {32'd0, out_data}, 64'h2);
        cycle(1'b0, 32'd0, 1'b1);
        check("drained_size", {54'd0, fifo_size}, 64'd0);
        check("drained_rdy", {63'd0, out_data_rdy}, 64'd0);
        check("drained_ptr", {54'd0, out_data_ptr}, 64'd2);

        // Pop while empty is ignored.
        cycle(1'b0, 32'd0, 1'b1);
        check("empty_pop_size", {54'd0, fifo_size}, 64'd0);

        for (int i = 0; i < 1023; i++) cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
        check("fill_size", {54'd0, fifo_size}, 64'd1023);
        cycle(1'b1, 32'hDEAD_0001, 1'b0);
        check("overflow_pulse", {63'd0, event_overflow}, 64'd1);
        check("overflow_size", {54'd0, fifo_size}, 64'd1023);
        cycle(1'b1, 32'hDEAD_0002, 1'b0);
        check("overflow_held", {63'd0, event_overflow}, 64'd1);
        cycle(1'b1, 32'h2000_0000, 1'b1);
        check("full_pushpop_no_pulse", {63'd0, event_overflow}, 64'd0);
        check("full_pushpop_size", {54'd0, fifo_size}, 64'd1023);

        for (int i = 0; i < 1023; i++) cycle(1'b0, 32'd0, 1'b1);
        check("drain_all_size", {54'd0, fifo_size}, 64'd0);
        check("drain_all_ptr", {54'd0, out_data_ptr}, 64'd2);

        // 1030 interleaved words carry both pointers past 1023.
        cycle(1'b1, 32'hA000_0000, 1'b0);
        for (int i = 1; i < 1030; i++) cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        check("wrap_ptr", {54'd0, out_data_ptr}, 64'd8);
        check("wrap_size", {54'd0, fifo_size}, 64'd0);

        // Asynchronous reset mid-operation with push and pop in flight.
        cycle(1'b1, 32'h3000_0001, 1'b0);
        cycle(1'b1, 32'h3000_0002, 1'b0);
        in_data = 32'h3000_0003;
        in_data_vld = 1'b1;
        out_data_vld = 1'b1;
        rst = 1'b1;
        #1;
        check("midreset_size", {54'd0, fifo_size}, 64'd0);
        check("midreset_rdy", {63'd0, out_data_rdy}, 64'd0);
        check("midreset_ptr", {54'd0, out_data_ptr}, 64'd0);
        exp_q.delete();
        m_rd = '0;
        @(posedge clk);
        #1;
        check("midreset_edge_size", {54'd0, fifo_size}, 64'd0);
        rst = 1'b0;
        in_data_vld = 1'b0;
        out_data_vld = 1'b0;
        cycle(1'b1, 32'h0000_0055, 1'b0);
        check("post_reset_head", {32'd0, out_data}, 64'h55);
        cycle(1'b0, 32'd0, 1'b1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
